// File: rtl/reg_dump.sv
// ---------------------------------------------------------------------------
// reg_dump
//   Walks a register file from index 0 to NREGS-1 and streams every register
//   out as bytes (most-significant byte first) over a valid/ready interface.
//   For each register the FSM spends one cycle presenting the index
//   (ADDR), one cycle latching the returned data (CAPTURE), and then one
//   cycle per byte while the consumer accepts (SEND).
//
// Parameters
//   N      register data width in bits (multiple of 8, 8..32)
//   NREGS  number of registers dumped (2..16)
//
// Ports
//   clk        single clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   start      one-cycle dump request, honoured only in IDLE
//   readnum    register-file read index
//   rdata      register-file read data, valid one cycle after readnum moves
//   out_valid  out_data holds a byte
//   out_data   byte stream
//   out_ready  consumer accepts the byte when high together with out_valid
//   busy       dump in progress
//   done       one-cycle pulse after the last byte has transferred
//
// Build option
//   REG_DUMP_HEADER_EN  when defined, a HEADER state is inserted between IDLE
//                       and ADDR that emits 0xA5 followed by NREGS before the
//                       register bytes.
// ---------------------------------------------------------------------------
module reg_dump #(
    parameter int N     = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [$clog2(NREGS)-1:0] readnum,
    input  logic [N-1:0]             rdata,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int IW    = $clog2(NREGS);
    localparam int BYTES = N / 8;

`ifdef REG_DUMP_HEADER_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_ADDR, S_CAPTURE, S_SEND, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CAPTURE, S_SEND, S_DONE
    } state_t;
`endif

    state_t         state_q,     state_d;
    logic [IW-1:0]  index_q,     index_d;
    logic [IW-1:0]  readnum_q,   readnum_d;
    logic [N-1:0]   holder_q,    holder_d;
    logic [3:0]     cnt_q,       cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_data_q,  out_data_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
`ifdef REG_DUMP_HEADER_EN
    logic           hdr_second_q, hdr_second_d;
`endif

    logic xfer;
    assign xfer = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        readnum_d   = readnum_q;
        holder_d    = holder_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef REG_DUMP_HEADER_EN
        hdr_second_d = hdr_second_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d   = '0;
                    readnum_d = '0;
                    busy_d    = 1'b1;
`ifdef REG_DUMP_HEADER_EN
                    state_d      = S_HEADER;
                    out_valid_d  = 1'b1;
                    out_data_d   = 8'hA5;
                    hdr_second_d = 1'b0;
`else
                    state_d   = S_ADDR;
`endif
                end
            end

`ifdef REG_DUMP_HEADER_EN
            S_HEADER: begin
                if (xfer) begin
                    if (!hdr_second_q) begin
                        out_data_d   = 8'(NREGS);
                        hdr_second_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = S_ADDR;
                    end
                end
            end
`endif

            // readnum already holds the index; rdata answers next cycle.
            S_ADDR: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                holder_d    = rdata;
                cnt_d       = 4'(BYTES);
                out_valid_d = 1'b1;
                out_data_d  = rdata[N-1 -: 8];
                state_d     = S_SEND;
            end

            S_SEND: begin
                if (xfer) begin
                    if (cnt_q > 4'd1) begin
                        // Shift so the next unsent byte sits at the top.
                        holder_d   = holder_q << 8;
                        out_data_d = holder_d[N-1 -: 8];
                        cnt_d      = cnt_q - 4'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        if (index_q == IW'(NREGS - 1)) begin
                            state_d   = S_DONE;
                            readnum_d = '0;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                        end else begin
                            index_d   = index_q + 1'b1;
                            readnum_d = index_q + 1'b1;
                            state_d   = S_ADDR;
                        end
                    end
                end
            end

            // done_q is high for this single cycle; start is not looked at.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            readnum_q   <= '0;
            holder_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REG_DUMP_HEADER_EN
            hdr_second_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            readnum_q   <= readnum_d;
            holder_q    <= holder_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REG_DUMP_HEADER_EN
            hdr_second_q <= hdr_second_d;
`endif
        end
    end

    assign readnum   = readnum_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// ---------------------------------------------------------------------------
// tb_reg_dump
//   Directed bench for reg_dump with default parameters. Expected bytes are
//   pushed to a queue when a dump is requested and popped by a monitor as
//   the consumer accepts them. A small register-file model answers readnum
//   with one cycle of latency and can scramble rdata on every cycle except
//   the one the dumper latches.
// ---------------------------------------------------------------------------
module tb_reg_dump;

    localparam int N     = 16;
    localparam int NREGS = 8;
    localparam int IW    = $clog2(NREGS);
    localparam int BPW   = N / 8;
    localparam int TOT   = NREGS * BPW;
`ifdef REG_DUMP_HEADER_EN
    localparam int H = 2;
`else
    localparam int H = 0;
`endif
    // start edge -> ADDR,CAPTURE + BPW sends per word, then DONE cycle
    localparam int EXP_CYC = (2 + BPW) * NREGS + 1 + H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] readnum;
    logic [N-1:0]  rdata;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    reg_dump #(.N(N), .NREGS(NREGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .readnum   (readnum),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_q[$];
    logic [N-1:0] regs [NREGS];
    bit   rand_mode   = 1'b0;
    bit   toggle_mode = 1'b0;
    int   nbytes   = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Register-file model plus a tracker of when the dumper sits in ADDR,
    // so rdata can be randomised everywhere except the CAPTURE cycle.
    logic addr_now;
    int   kcnt;
    int   m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_now <= 1'b0;
            kcnt     <= 0;
            rdata    <= '0;
        end else begin
            addr_now <= 1'b0;
            if (start && !busy && !done) begin
                kcnt     <= 0;
                addr_now <= (H == 0);
            end else if (out_valid && out_ready) begin
                m = kcnt + 1 - H;
                if (m >= 0 && (m % BPW) == 0 && m < TOT) addr_now <= 1'b1;
                kcnt <= kcnt + 1;
            end
            rdata <= (rand_mode && !addr_now) ? N'($urandom) : regs[readnum];
        end
    end

    always @(posedge clk) begin
        #1;
        if (toggle_mode) out_ready = ~out_ready;
    end

    // Monitor: compare accepted bytes against the scoreboard and check that
    // a stalled byte stays put until it is taken.
    bit         stall_pend = 1'b0;
    logic [7:0] stall_data;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (stall_pend) check("stall_stable", 32'(out_data), 32'(stall_data));
            if (out_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
                else check("byte", 32'(out_data), 32'(exp_q.pop_front()));
                nbytes++;
                stall_pend = 1'b0;
            end else begin
                stall_pend = 1'b1;
                stall_data = out_data;
            end
        end else begin
            stall_pend = 1'b0;
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic push_expected();
`ifdef REG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NREGS));
`endif
        for (int i = 0; i < NREGS; i++)
            for (int b = BPW - 1; b >= 0; b--)
                exp_q.push_back(regs[i][b*8 +: 8]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_dump(input bit chk_len);
        int cyc;
        int d0;
        d0 = done_cnt;
        push_expected();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(cyc);
        if (chk_len) check("dump_cycles", cyc, EXP_CYC);
        check("busy_in_done", 32'(busy), 32'd0);
        check("readnum_in_done", 32'(readnum), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", done_cnt, d0 + 1);
        check("all_bytes_seen", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int cyc;
        for (int i = 0; i < NREGS; i++) regs[i] = N'(16'h1100 + i);

        // Reset values
        #22;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_readnum",   32'(readnum),   32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);

        // First start right on the first edge after reset release
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_expected();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_first_start", 32'(busy), 32'd1);
        wait_done(cyc);
        check("first_dump_cycles", cyc, EXP_CYC);
        @(posedge clk); #1;
        check("first_all_bytes", exp_q.size(), 0);

        // Plain dump with the consumer always ready
        run_dump(1'b1);

        // Consumer ready on alternate cycles
        toggle_mode = 1'b1;
        run_dump(1'b0);
        toggle_mode = 1'b0;
        out_ready   = 1'b1;

        // Start held high through the dump and into the DONE cycle
        d0 = done_cnt;
        push_expected();
        pulse_start();
        start = 1'b1;
        wait_done(cyc);
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("restart_ignored_busy", 32'(busy), 32'd0);
        check("restart_single_done", done_cnt, d0 + 1);
        check("restart_all_bytes", exp_q.size(), 0);

        // Reset after the fifth byte transfers
        d0 = done_cnt;
        nbytes = 0;
        push_expected();
        pulse_start();
        cyc = 0;
        while (nbytes < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("five_bytes_reached", nbytes, 5);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_readnum",   32'(readnum),   32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);
        rst_n = 1'b1;
        run_dump(1'b1);

        // Scrambled rdata outside the capture cycle, fresh register contents
        for (int i = 0; i < NREGS; i++) regs[i] = N'($urandom);
        rand_mode = 1'b1;
        run_dump(1'b1);
        rand_mode = 1'b0;

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter N, default 16, register data width (multiple of 8, 8..32).
REQ-002 SHALL have parameter NREGS, default 8, number of registers dumped (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port readnum  output  $clog2(NREGS)  register-file read index.
REQ-007 SHALL have port rdata  input  N  register-file read data, valid one cycle after readnum changes.
REQ-008 SHALL have port out_valid  output  1  out_data holds a byte.
REQ-009 SHALL have port out_data  output  8  byte stream to the consumer.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the byte when high with out_valid.
REQ-011 SHALL have port busy  output  1  dump in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-013 SHALL implement states IDLE, ADDR, CAPTURE, SEND, DONE.
REQ-014 IDLE: start=1 -> ADDR, index cleared to 0, busy=1 from the next cycle.
REQ-015 ADDR: readnum driven with index for one full cycle -> CAPTURE.
REQ-016 CAPTURE: rdata latched into an N-bit shift holder, byte count set to N/8 -> SEND.
REQ-017 SEND: out_valid=1; out_data = most-significant unsent byte (big-endian within word).
REQ-018 Transfer occurs on a cycle with out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 After the last byte of a word: index<NREGS-1 -> index+1, ADDR; index=NREGS-1 -> DONE.
REQ-020 DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
REQ-021 start SHALL be ignored when not in IDLE; start in the DONE cycle is also ignored.
REQ-022 Back-to-back transfers SHALL sustain one byte per cycle within a word; 2-cycle gap (ADDR, CAPTURE) between words.
REQ-023 Total dump length SHALL be NREGS*N/8 bytes (16 for defaults); index never wraps past NREGS-1.
REQ-024 rdata changes outside CAPTURE SHALL not affect emitted bytes.
REQ-025 readnum SHALL equal 0 in IDLE and DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, readnum=0, out_valid=0, out_data=0, busy=0, done=0, index and holder cleared.
REQ-027 Reset mid-dump SHALL abort without a done pulse; the next start begins again at register 0.
REQ-028 First start SHALL be accepted on the first posedge after rst_n rises.

Configuration
REQ-029 Macro REG_DUMP_HEADER_EN SHALL, when defined, add state HEADER between IDLE and ADDR emitting byte 0xA5 then byte NREGS under the same handshake, dump length +2.
REQ-030 Without REG_DUMP_HEADER_EN, IDLE SHALL go directly to ADDR and no header bytes SHALL appear.

Verification
REQ-031 Defaults, regs R0..R7 = 16'h1100+i, out_ready=1, pulse start -> bytes 11 00 11 01 ... 11 07 (16 bytes), done pulse once, busy low after.
REQ-032 out_ready toggling 1010..., same data -> identical 16-byte sequence, out_data stable during every stall cycle.
REQ-033 Assert start repeatedly during a dump -> exactly 16 bytes, single done pulse.
REQ-034 rst_n low after 5th byte transferred -> out_valid/busy drop same cycle, no done; restart yields full sequence from 11 00.
REQ-035 Change rdata every cycle outside CAPTURE (random), stable in CAPTURE -> emitted bytes match CAPTURE-cycle values only.
REQ-036 REG_DUMP_HEADER_EN defined -> stream A5 08 11 00 ... 11 07 (18 bytes).
